// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer; the debug unit decodes o_state with these.
package pc_seq_pkg;

  typedef logic [1:0] pc_state_t;

  localparam pc_state_t ST_IDLE   = 2'b00;
  localparam pc_state_t ST_RUN    = 2'b01;
  localparam pc_state_t ST_STEP   = 2'b10;
  localparam pc_state_t ST_HALTED = 2'b11;

  localparam int unsigned INSTR_BYTES_DEF = 4;

  function automatic logic is_active(pc_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Debug/hazard/resolution bundle for pc_sequencer. Optional o_cycle_count under PC_SEQ_CYCLE_COUNT_EN.
interface pc_sequencer_if #(
  parameter int unsigned NBITS = 32
);
  import pc_seq_pkg::*;

  logic [NBITS-1:0] i_pc;
  logic             i_run_req;
  logic             i_step_req;
  logic             i_pause_req;
  logic             i_halt_instr;
  logic             i_hazard_detected;
  logic             i_branch_taken;
  logic [NBITS-1:0] i_branch_target;
  logic             i_jump;
  logic [NBITS-1:0] i_jump_target;
  logic [NBITS-1:0] o_next_pc;
  logic             o_pc_enable;
  logic             o_if_id_flush;
  pc_state_t        o_state;
  logic             o_step_done;
  logic             o_halted;
`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [31:0]      o_cycle_count;
`endif

  modport master (
    output i_pc, i_run_req, i_step_req, i_pause_req, i_halt_instr, i_hazard_detected,
           i_branch_taken, i_branch_target, i_jump, i_jump_target,
    input  o_next_pc, o_pc_enable, o_if_id_flush, o_state, o_step_done, o_halted
`ifdef PC_SEQ_CYCLE_COUNT_EN
    , input o_cycle_count
`endif
  );

  modport slave (
    input  i_pc, i_run_req, i_step_req, i_pause_req, i_halt_instr, i_hazard_detected,
           i_branch_taken, i_branch_target, i_jump, i_jump_target,
    output o_next_pc, o_pc_enable, o_if_id_flush, o_state, o_step_done, o_halted
`ifdef PC_SEQ_CYCLE_COUNT_EN
    , output o_cycle_count
`endif
  );

endinterface

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC priority select: reset vector, branch, jump, then sequential increment.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned      NBITS        = 32,
  parameter logic [NBITS-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INSTR_BYTES  = INSTR_BYTES_DEF
) (
  input  logic             sel_reset_i,
  input  logic             branch_taken_i,
  input  logic [NBITS-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [NBITS-1:0] jump_target_i,
  input  logic [NBITS-1:0] pc_i,
  output logic [NBITS-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i + NBITS'(INSTR_BYTES);
    if (sel_reset_i)         next_pc_o = RESET_VECTOR;
    else if (branch_taken_i) next_pc_o = branch_target_i;
    else if (jump_i)         next_pc_o = jump_target_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: run/step/pause/halt FSM, PC enable, IF/ID flush.
// Optional cycle counter under PC_SEQ_CYCLE_COUNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      NBITS        = 32,
  parameter logic [NBITS-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INSTR_BYTES  = INSTR_BYTES_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pc_sequencer_if.slave bus
);

  pc_state_t state_q, state_d;
  logic      advanced_q;
  logic      step_done_q;
  logic      halted_q;
  logic      pc_en;

  assign pc_en = is_active(state_q) & ~bus.i_hazard_detected & ~bus.i_halt_instr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_run_req)       state_d = ST_RUN;
        else if (bus.i_step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (bus.i_halt_instr)       state_d = ST_HALTED;
        else if (bus.i_pause_req)   state_d = ST_IDLE;
      end
      ST_STEP: begin
        // A stalled step is held, not consumed; halt still wins over the stall.
        if (bus.i_halt_instr)            state_d = ST_HALTED;
        else if (!bus.i_hazard_detected) state_d = ST_IDLE;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      advanced_q  <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      advanced_q  <= advanced_q | pc_en;
      step_done_q <= (state_q == ST_STEP) & pc_en;
      halted_q    <= (state_d == ST_HALTED);
    end
  end

`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst)                  cycle_count_q <= '0;
    else if (is_active(state_q)) cycle_count_q <= cycle_count_q + 32'd1;
  end

  assign bus.o_cycle_count = cycle_count_q;
`endif

  pc_next_mux #(
    .NBITS        (NBITS),
    .RESET_VECTOR (RESET_VECTOR),
    .INSTR_BYTES  (INSTR_BYTES)
  ) u_next_mux (
    .sel_reset_i     ((state_q == ST_IDLE) & ~advanced_q),
    .branch_taken_i  (bus.i_branch_taken),
    .branch_target_i (bus.i_branch_target),
    .jump_i          (bus.i_jump),
    .jump_target_i   (bus.i_jump_target),
    .pc_i            (bus.i_pc),
    .next_pc_o       (bus.o_next_pc)
  );

  assign bus.o_pc_enable   = pc_en;
  assign bus.o_if_id_flush = pc_en & (bus.i_branch_taken | bus.i_jump);
  assign bus.o_state       = state_q;
  assign bus.o_step_done   = step_done_q;
  assign bus.o_halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios, then random stimulus vs a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.NBITS(32)) bus ();

  pc_sequencer #(
    .NBITS        (32),
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode named after the spec's states, plus "ever advanced" flag.
  typedef enum int {M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3} mode_t;
  mode_t       m_mode;
  bit          m_advanced, m_step_done, m_halted, m_valid;
  int unsigned m_cnt;

  function automatic bit m_en();
    return (m_mode == M_RUN || m_mode == M_STEP) && !bus.i_hazard_detected && !bus.i_halt_instr;
  endfunction

  function automatic logic [31:0] m_npc();
    if (m_mode == M_IDLE && !m_advanced) return RV;
    if (bus.i_branch_taken) return bus.i_branch_target;
    if (bus.i_jump)         return bus.i_jump_target;
    return bus.i_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = M_IDLE; m_advanced = 0; m_step_done = 0; m_halted = 0; m_cnt = 0;
      m_valid = 1;
    end else if (m_valid) begin
      bit en;
      en = m_en();
      m_step_done = (m_mode == M_STEP) && en;
      if (en) m_advanced = 1;
      if (m_mode == M_RUN || m_mode == M_STEP) m_cnt++;
      case (m_mode)
        M_IDLE:  if (bus.i_run_req) m_mode = M_RUN; else if (bus.i_step_req) m_mode = M_STEP;
        M_RUN:   if (bus.i_halt_instr) m_mode = M_HALTED; else if (bus.i_pause_req) m_mode = M_IDLE;
        M_STEP:  if (bus.i_halt_instr) m_mode = M_HALTED; else if (!bus.i_hazard_detected) m_mode = M_IDLE;
        default: m_mode = M_HALTED;
      endcase
      m_halted = (m_mode == M_HALTED);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      bit en;
      en = m_en();
      chk("state",     32'(bus.o_state),       32'(m_mode));
      chk("pc_enable", 32'(bus.o_pc_enable),   32'(en));
      chk("next_pc",   bus.o_next_pc,          m_npc());
      chk("flush",     32'(bus.o_if_id_flush), 32'(en && (bus.i_branch_taken || bus.i_jump)));
      chk("step_done", 32'(bus.o_step_done),   32'(m_step_done));
      chk("halted",    32'(bus.o_halted),      32'(m_halted));
`ifdef PC_SEQ_CYCLE_COUNT_EN
      chk("cycle_count", bus.o_cycle_count, m_cnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_run_req = 0; bus.i_step_req = 0; bus.i_pause_req = 0; bus.i_halt_instr = 0;
    bus.i_hazard_detected = 0; bus.i_branch_taken = 0; bus.i_jump = 0;
  endtask

  initial begin
    m_valid = 0;
    rst = 0;
    idle_inputs();
    bus.i_pc = 32'h0; bus.i_branch_target = 32'h0; bus.i_jump_target = 32'h0;

    // Reset for two cycles, then release.
    tick(); tick();
    rst = 1;
    #1;
    chk("rst_state", 32'(bus.o_state), 32'h0);
    chk("rst_en",    32'(bus.o_pc_enable), 32'h0);
    chk("rst_npc",   bus.o_next_pc, 32'h0);
    chk("rst_sd",    32'(bus.o_step_done), 32'h0);

    // Run request; sequential next PC; hazard gating.
    bus.i_pc = 32'h10; bus.i_run_req = 1;
    tick(); bus.i_run_req = 0; #1;
    chk("run_state", 32'(bus.o_state), 32'h1);
    chk("run_en",    32'(bus.o_pc_enable), 32'h1);
    chk("run_npc",   bus.o_next_pc, 32'h14);
    bus.i_hazard_detected = 1; #1;
    chk("run_haz_en", 32'(bus.o_pc_enable), 32'h0);
    bus.i_hazard_detected = 0;

    // Branch beats jump; flush suppressed under stall.
    tick();
    bus.i_branch_taken = 1; bus.i_branch_target = 32'h80;
    bus.i_jump = 1; bus.i_jump_target = 32'h40; #1;
    chk("br_npc",   bus.o_next_pc, 32'h80);
    chk("br_flush", 32'(bus.o_if_id_flush), 32'h1);
    tick();
    bus.i_hazard_detected = 1; #1;
    chk("br_haz_flush", 32'(bus.o_if_id_flush), 32'h0);
    tick();
    idle_inputs(); bus.i_pause_req = 1;
    tick(); bus.i_pause_req = 0; #1;
    chk("pause_state", 32'(bus.o_state), 32'h0);

    // Step held two cycles by hazard, then one advance and a single step_done pulse.
    bus.i_step_req = 1; bus.i_hazard_detected = 1;
    tick(); bus.i_step_req = 0; #1;
    chk("step_state1", 32'(bus.o_state), 32'h2);
    chk("step_en1",    32'(bus.o_pc_enable), 32'h0);
    tick(); #1;
    chk("step_state2", 32'(bus.o_state), 32'h2);
    bus.i_hazard_detected = 0; #1;
    chk("step_en3", 32'(bus.o_pc_enable), 32'h1);
    tick(); #1;
    chk("step_back_idle", 32'(bus.o_state), 32'h0);
    chk("step_done_hi",   32'(bus.o_step_done), 32'h1);
    tick(); #1;
    chk("step_done_lo", 32'(bus.o_step_done), 32'h0);

    // Halt beats pause; HALTED ignores run requests.
    bus.i_run_req = 1;
    tick(); bus.i_run_req = 0;
    bus.i_halt_instr = 1; bus.i_pause_req = 1; #1;
    chk("halt_en", 32'(bus.o_pc_enable), 32'h0);
    tick(); bus.i_halt_instr = 0; bus.i_pause_req = 0; #1;
    chk("halt_state",  32'(bus.o_state), 32'h3);
    chk("halt_halted", 32'(bus.o_halted), 32'h1);
    bus.i_run_req = 1;
    tick(); tick(); #1;
    chk("halt_sticky", 32'(bus.o_state), 32'h3);
    chk("halt_en2",    32'(bus.o_pc_enable), 32'h0);
    bus.i_run_req = 0;

    // Reset exits HALTED and re-arms the reset vector; PC wrap.
    rst = 0;
    tick(); rst = 1; #1;
    chk("rearm_state", 32'(bus.o_state), 32'h0);
    bus.i_pc = 32'h100; #1;
    chk("rearm_npc", bus.o_next_pc, RV);
    bus.i_run_req = 1;
    tick(); bus.i_run_req = 0;
    bus.i_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_npc", bus.o_next_pc, 32'h0);
    bus.i_pause_req = 1;
    tick(); bus.i_pause_req = 0;

    // Reset mid-step: back to IDLE with no step_done.
    bus.i_step_req = 1; bus.i_hazard_detected = 1;
    tick(); bus.i_step_req = 0; #1;
    chk("mid_step_state", 32'(bus.o_state), 32'h2);
    rst = 0;
    tick(); rst = 1; bus.i_hazard_detected = 0; #1;
    chk("mid_rst_state", 32'(bus.o_state), 32'h0);
    chk("mid_rst_sd",    32'(bus.o_step_done), 32'h0);
    tick(); #1;
    chk("mid_rst_sd2", 32'(bus.o_step_done), 32'h0);

    // Random phase, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst                   = ($urandom_range(99) != 0);
      bus.i_run_req         = ($urandom_range(5) == 0);
      bus.i_step_req        = ($urandom_range(5) == 0);
      bus.i_pause_req       = ($urandom_range(7) == 0);
      bus.i_halt_instr      = ($urandom_range(39) == 0);
      bus.i_hazard_detected = ($urandom_range(3) == 0);
      bus.i_branch_taken    = ($urandom_range(3) == 0);
      bus.i_jump            = ($urandom_range(3) == 0);
      bus.i_branch_target   = $urandom;
      bus.i_jump_target     = $urandom;
      bus.i_pc              = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom;
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the fetch-stage Program Counter register.
- Selects the next PC from the sequential, branch and jump sources, and gates PC advance by run mode and load-use hazard.
- Generates the IF/ID flush on control transfers.
- Implements the debug unit's run / single-step / pause / end-of-program sequencing; sits between the debug unit, hazard unit, branch/jump resolution and the PC register.

Parameters:
NBITS, 32, PC and address width
RESET_VECTOR, 0, PC value driven on o_next_pc while in IDLE after reset (program start)
INSTR_BYTES, 4, sequential increment

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-low (0 = reset)
i_pc  in  NBITS  current PC register value
i_run_req  in  1  debug unit: enter continuous run
i_step_req  in  1  debug unit: execute exactly one PC advance
i_pause_req  in  1  debug unit: stop advancing, return to IDLE
i_halt_instr  in  1  decode stage saw HALT instruction
i_hazard_detected  in  1  load-use stall from hazard unit
i_branch_taken  in  1  branch resolved taken
i_branch_target  in  NBITS  branch target address
i_jump  in  1  jump resolved
i_jump_target  in  NBITS  jump target address
o_next_pc  out  NBITS  value to load into PC
o_pc_enable  out  1  PC load enable
o_if_id_flush  out  1  squash IF/ID register
o_state  out  2  FSM state encoding
o_step_done  out  1  one-cycle pulse when a step completed
o_halted  out  1  high in HALTED

Behaviour:
- States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
- Reset (i_rst==0 at posedge): state=IDLE, o_step_done=0, o_halted=0. Reset wins over every other input in any state, including mid-step.
- IDLE:
  - i_run_req -> RUN; else i_step_req -> STEP. Run beats step when both are asserted.
  - Transition takes one cycle; first possible PC advance is the cycle after the request.
- RUN:
  - i_halt_instr -> HALTED; else i_pause_req -> IDLE. Halt beats pause.
- STEP:
  - If the advance condition holds this cycle (~i_hazard_detected & ~i_halt_instr): -> IDLE, and o_step_done=1 on the next cycle for exactly 1 cycle.
  - If i_hazard_detected: stay in STEP; the step is not consumed.
  - i_halt_instr -> HALTED, no step_done.
- HALTED: terminal; exits only by reset. o_halted=1 (registered, i.e. asserted from the cycle after entry).
- o_pc_enable (combinational) = (state==RUN | state==STEP) & ~i_hazard_detected & ~i_halt_instr. Forced 0 in IDLE/HALTED and in the HALT-detect cycle.
- o_next_pc (combinational), priority order:
  1. state==IDLE & PC never advanced since reset: RESET_VECTOR
  2. i_branch_taken: i_branch_target
  3. i_jump: i_jump_target
  4. otherwise: i_pc + INSTR_BYTES, modulo 2^NBITS (0xFFFFFFFC -> 0x00000000).
- o_if_id_flush = o_pc_enable & (i_branch_taken | i_jump). No flush while stalled; the branch is re-presented by the pipeline.
- Inputs i_run_req/i_step_req are ignored outside IDLE; i_pause_req is ignored outside RUN.

Optional Feature:
- Macro PC_SEQ_CYCLE_COUNT_EN.
- Defined: adds output o_cycle_count [31:0]; increments each cycle state is RUN or STEP; holds otherwise; cleared by reset; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package pc_seq_pkg holds the state encodings (IDLE/RUN/STEP/HALTED) and the INSTR_BYTES default, also used by the debug unit to decode o_state.
- Next-PC mux as sub-module pc_next_mux (priority select + increment), purely combinational; FSM and counter stay in pc_sequencer.

Test Plan:
- Reset with i_rst=0 for 2 cycles, then release -> state=IDLE, o_pc_enable=0, o_next_pc=0x0, o_step_done=0.
- i_run_req pulse, i_pc=0x10 -> state RUN next cycle; o_pc_enable=1, o_next_pc=0x14; with i_hazard_detected=1 -> o_pc_enable=0.
- RUN, i_branch_taken=1, i_branch_target=0x80, i_jump=1, i_jump_target=0x40 -> o_next_pc=0x80, o_if_id_flush=1; same with hazard -> o_if_id_flush=0.
- IDLE, i_step_req with i_hazard_detected=1 for 2 cycles then 0 -> stays STEP 2 cycles, one advance, back to IDLE, o_step_done high exactly 1 cycle.
- RUN, i_halt_instr=1 and i_pause_req=1 together -> o_pc_enable=0 that cycle, state HALTED, o_halted=1; i_run_req ignored until i_rst=0.
- RUN, i_pc=0xFFFFFFFC -> o_next_pc=0x00000000; assert i_rst=0 mid-STEP -> IDLE next cycle, no o_step_done.
